alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter NUM_REQ, default 2, number of requesters sharing the ALU; legal range 2..8.
REQ-003 Parameter CTRL_WIDTH, default 3, ALU operation code width.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  NUM_REQ  per-requester operation request.
REQ-007 req_ready  output  NUM_REQ  per-requester accept strobe; at most one bit high.
REQ-008 req_a  input  NUM_REQ x DATA_WIDTH  operand A (RD1) per requester.
REQ-009 req_rd2  input  NUM_REQ x DATA_WIDTH  register operand B (RD2) per requester.
REQ-010 req_imm  input  NUM_REQ x DATA_WIDTH  sign-extended immediate per requester.
REQ-011 req_alusrc  input  NUM_REQ  operand-B select per requester; 0 selects RD2, 1 selects the immediate.
REQ-012 req_ctrl  input  NUM_REQ x CTRL_WIDTH  ALU operation code per requester.
REQ-013 alu_a, alu_in0, alu_in1  output  DATA_WIDTH each  operand A and the two operand-mux inputs.
REQ-014 alu_src  output  1  operand-mux select.
REQ-015 alu_ctrl  output  CTRL_WIDTH  ALU operation code.
REQ-016 alu_result  input  DATA_WIDTH  combinational ALU result.
REQ-017 alu_zero  input  1  combinational ALU zero flag.
REQ-018 rsp_valid  output  1  response available.
REQ-019 rsp_ready  input  1  response consumer ready.
REQ-020 rsp_id  output  clog2(NUM_REQ)  index of the requester the response belongs to.
REQ-021 rsp_data  output  DATA_WIDTH  captured ALU result.
REQ-022 rsp_zero  output  1  captured ALU zero flag.

Function
REQ-023 FSM states SHALL be IDLE, EXEC and RESP.
REQ-024 IDLE with any req_valid high: grant one requester g, assert req_ready[g] combinationally in that cycle, latch that requester's operands, alusrc, ctrl and id, then go to EXEC; with no req_valid high, stay in IDLE.
REQ-025 EXEC: drive the latched values on alu_a/alu_in0/alu_in1/alu_src/alu_ctrl for exactly one cycle, capture alu_result and alu_zero into rsp_data and rsp_zero at the clock edge, then go to RESP.
REQ-026 RESP: hold rsp_valid high and rsp_id/rsp_data/rsp_zero stable until rsp_valid && rsp_ready; on that edge go to IDLE.
REQ-027 Latency from accept to rsp_valid SHALL be 2 cycles; peak throughput SHALL be one operation per 3 cycles.
REQ-028 Outside EXEC, all ALU-side outputs SHALL be 0.
REQ-029 req_ready SHALL be 0 in EXEC and RESP; requests arriving in those states wait without being lost.
REQ-030 Round-robin grant: pointer ptr; grant the first valid index at or after ptr, wrapping NUM_REQ-1 to 0; after a grant, ptr = (g+1) mod NUM_REQ.
REQ-031 A requester dropping req_valid before its grant receives no grant and no response.
REQ-032 Operands SHALL pass through unmodified: no arithmetic, truncation or extension in this block.

Reset
REQ-033 With rst high: state = IDLE, ptr = 0, req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_zero = 0, all ALU-side outputs = 0.
REQ-034 Reset asserted mid-operation (EXEC or RESP) SHALL discard the in-flight operation; no response is produced.

Configuration
REQ-035 With macro ALU_ARB_FIXED_PRIO_EN defined, grant SHALL be fixed priority (lowest valid index wins) and ptr SHALL be held at 0.
REQ-036 With ALU_ARB_FIXED_PRIO_EN undefined, grant SHALL be round-robin per REQ-030.

Structure
REQ-037 Package alu_arb_pkg SHALL hold the FSM state enum typedef, the CTRL_WIDTH default and the DATA_WIDTH default.
REQ-038 Grant logic SHALL live in one sub-module, rr_picker, taking the valid vector and ptr and returning a one-hot grant plus the grant index.

Verification
REQ-039 Single request: reset, req_valid[0]=1, a=5, rd2=7, alusrc=0, ctrl=ADD, ALU model adds -> req_ready[0] in cycle 0, rsp_valid at cycle 2 with data=12, id=0, zero=0.
REQ-040 Immediate select: a=3, imm=0xFFFFFFFD (-3), alusrc=1, ADD -> alu_src=1 in EXEC, rsp_data=0, rsp_zero=1.
REQ-041 Contention, round-robin build: both requesters valid continuously -> grants alternate 0,1,0,1; with ALU_ARB_FIXED_PRIO_EN defined -> grants 0,0,0,0.
REQ-042 Backpressure: rsp_ready=0 for 4 cycles -> rsp_valid and rsp_data stable and req_ready=0 throughout; rsp_ready=1 -> back to IDLE next cycle.
REQ-043 Reset mid-op: assert rst during EXEC -> next cycle all outputs 0, no rsp_valid afterwards, ptr=0.
REQ-044 Wrap-around: NUM_REQ=4, only requester 3 then requester 0 valid -> ptr goes 0 to 0 (grant 3 wraps), then 1.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared FSM state type and width defaults for the ALU arbiter.
package alu_arb_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned CTRL_WIDTH_DEF = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    EXEC = ST_EXEC,
    RESP = ST_RESP
  } state_t;

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Grant picker: first valid index at or after ptr, wrapping to 0; one-hot grant plus index.
module rr_picker #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       found
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  int unsigned pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!found && valid[IDX_W'(pos)]) begin
        grant[IDX_W'(pos)] = 1'b1;
        idx                = IDX_W'(pos);
        found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters via an IDLE/EXEC/RESP sequence.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned CTRL_WIDTH = CTRL_WIDTH_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_rd2,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_imm,
  input  logic [NUM_REQ-1:0]                   req_alusrc,
  input  logic [NUM_REQ-1:0][CTRL_WIDTH-1:0]   req_ctrl,
  output logic [DATA_WIDTH-1:0]                alu_a,
  output logic [DATA_WIDTH-1:0]                alu_in0,
  output logic [DATA_WIDTH-1:0]                alu_in1,
  output logic                                 alu_src,
  output logic [CTRL_WIDTH-1:0]                alu_ctrl,
  input  logic [DATA_WIDTH-1:0]                alu_result,
  input  logic                                 alu_zero,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]                rsp_data,
  output logic                                 rsp_zero
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d, gnt_idx;
  logic [NUM_REQ-1:0] gnt_vec;
  logic            gnt_any;
  logic            accept;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (gnt_vec),
    .idx   (gnt_idx),
    .found (gnt_any)
  );

  // Accept strobe is combinational so the requester sees it in the grant cycle.
  assign accept    = !rst && (state_q == IDLE) && gnt_any;
  assign req_ready = accept ? gnt_vec : '0;

  always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    ptr_d = '0;
`else
    ptr_d = ptr_q;
    if (accept) ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_any) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_valid && rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // ALU-side registers hold the granted operands only while in EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a     <= '0;
      alu_in0   <= '0;
      alu_in1   <= '0;
      alu_src   <= 1'b0;
      alu_ctrl  <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            alu_a    <= req_a[gnt_idx];
            alu_in0  <= req_rd2[gnt_idx];
            alu_in1  <= req_imm[gnt_idx];
            alu_src  <= req_alusrc[gnt_idx];
            alu_ctrl <= req_ctrl[gnt_idx];
            rsp_id   <= gnt_idx;
          end
        end
        EXEC: begin
          alu_a     <= '0;
          alu_in0   <= '0;
          alu_in1   <= '0;
          alu_src   <= 1'b0;
          alu_ctrl  <= '0;
          rsp_data  <= alu_result;
          rsp_zero  <= alu_zero;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter (NUM_REQ=4); follows ALU_ARB_FIXED_PRIO_EN if defined.
module tb_alu_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 4;
  localparam int unsigned CW = 3;
  localparam int unsigned IW = 2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd4;

  localparam int S_IDLE = 0;
  localparam int S_EXEC = 1;
  localparam int S_RESP = 2;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic          zero;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0]         req_valid, req_ready, req_alusrc;
  logic [NR-1:0][DW-1:0] req_a, req_rd2, req_imm;
  logic [NR-1:0][CW-1:0] req_ctrl;
  logic [DW-1:0] alu_a, alu_in0, alu_in1, alu_result, rsp_data;
  logic          alu_src, alu_zero, rsp_valid, rsp_ready, rsp_zero;
  logic [CW-1:0] alu_ctrl;
  logic [IW-1:0] rsp_id;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  rsp_t sb[$];
  int   glog[$];
  int   gcyc[$];

  alu_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .CTRL_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_rd2(req_rd2), .req_imm(req_imm),
    .req_alusrc(req_alusrc), .req_ctrl(req_ctrl),
    .alu_a(alu_a), .alu_in0(alu_in0), .alu_in1(alu_in1),
    .alu_src(alu_src), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_zero(rsp_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] alu_ref(input logic [CW-1:0] c, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (c)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << b[4:0];
      3'd6:    return a >> b[4:0];
      default: return {31'b0, $signed(a) < $signed(b)};
    endcase
  endfunction

  function automatic int pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++)
      if (v[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  // External ALU behaviour
  always_comb begin
    alu_result = alu_ref(alu_ctrl, alu_a, alu_src ? alu_in1 : alu_in0);
    alu_zero   = (alu_result == '0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] rd2,
                         input logic [DW-1:0] imm, input logic src, input logic [CW-1:0] c);
    req_a[i]      = a;
    req_rd2[i]    = rd2;
    req_imm[i]    = imm;
    req_alusrc[i] = src;
    req_ctrl[i]   = c;
  endtask

  // Cycle model of the arbiter: predicts grants and pushes expected responses.
  int            m_state = S_IDLE;
  int            m_ptr   = 0;
  int            n_rsp   = 0;
  logic [DW-1:0] m_a, m_rd2, m_imm;
  logic          m_src;
  logic [CW-1:0] m_ctrl;
  logic [NR-1:0] mon_er;
  int            mon_g;
  rsp_t          mon_e;

  always @(negedge clk) begin
    if (mon_en) begin
      mon_er = '0;
      mon_g  = -1;
      if (!rst && m_state == S_IDLE && |req_valid) begin
        mon_g = pick(req_valid, m_ptr);
        mon_er[mon_g] = 1'b1;
      end
      check("req_ready", 64'(req_ready), 64'(mon_er));
      if (m_state == S_EXEC) begin
        check("alu_a", 64'(alu_a), 64'(m_a));
        check("alu_in0", 64'(alu_in0), 64'(m_rd2));
        check("alu_in1", 64'(alu_in1), 64'(m_imm));
        check("alu_src", 64'(alu_src), 64'(m_src));
        check("alu_ctrl", 64'(alu_ctrl), 64'(m_ctrl));
      end else begin
        check("alu_quiet", 64'(|{alu_a, alu_in0, alu_in1, alu_src, alu_ctrl}), 64'(0));
      end
      check("rsp_valid", 64'(rsp_valid), 64'(m_state == S_RESP));
      if (m_state == S_RESP && sb.size() > 0) begin
        check("rsp_id", 64'(rsp_id), 64'(sb[0].id));
        check("rsp_data", 64'(rsp_data), 64'(sb[0].data));
        check("rsp_zero", 64'(rsp_zero), 64'(sb[0].zero));
      end
      if (rst) begin
        m_state = S_IDLE;
        m_ptr   = 0;
        sb.delete();
      end else begin
        case (m_state)
          S_IDLE: begin
            if (mon_g >= 0) begin
              m_a    = req_a[mon_g];
              m_rd2  = req_rd2[mon_g];
              m_imm  = req_imm[mon_g];
              m_src  = req_alusrc[mon_g];
              m_ctrl = req_ctrl[mon_g];
              mon_e.id   = IW'(mon_g);
              mon_e.data = alu_ref(m_ctrl, m_a, m_src ? m_imm : m_rd2);
              mon_e.zero = (mon_e.data == '0);
              sb.push_back(mon_e);
              glog.push_back(mon_g);
              gcyc.push_back(cyc);
`ifdef ALU_ARB_FIXED_PRIO_EN
              m_ptr = 0;
`else
              m_ptr = (mon_g + 1) % NR;
`endif
              m_state = S_EXEC;
            end
          end
          S_EXEC: m_state = S_RESP;
          default: begin
            if (rsp_ready) begin
              void'(sb.pop_front());
              n_rsp++;
              m_state = S_IDLE;
            end
          end
        endcase
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    int            n;
    int            mark;
    int            exp_g[4];
    bit            saw3;
    logic [NR-1:0] acc;

    rst = 1'b1;
    req_valid = '0; req_a = '0; req_rd2 = '0; req_imm = '0; req_alusrc = '0; req_ctrl = '0;
    rsp_ready = 1'b1;
    step();
    mon_en = 1'b1;

    // Reset state; a request during reset is not accepted
    req_valid = 4'b0001;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp", 64'({rsp_valid, rsp_id, rsp_data, rsp_zero}), 64'(0));
    check("rst_alu", 64'(alu_a | alu_in0 | alu_in1), 64'(0));
    check("rst_alu_ctl", 64'({alu_src, alu_ctrl}), 64'(0));
    step();
    rst = 1'b0;
    req_valid = '0;

    // Single request: 5 + 7
    set_req(0, 32'd5, 32'd7, 32'd0, 1'b0, OP_ADD);
    req_valid = 4'b0001;
    @(negedge clk);
    check("t1_ready_c0", 64'(req_ready), 64'(4'b0001));
    step();
    req_valid = '0;
    @(negedge clk);
    check("t1_no_rsp_c1", 64'(rsp_valid), 64'(0));
    check("t1_alu_a", 64'(alu_a), 64'(5));
    check("t1_alu_in0", 64'(alu_in0), 64'(7));
    @(negedge clk);
    check("t1_rsp_valid_c2", 64'(rsp_valid), 64'(1));
    check("t1_rsp_data", 64'(rsp_data), 64'(12));
    check("t1_rsp_id", 64'(rsp_id), 64'(0));
    check("t1_rsp_zero", 64'(rsp_zero), 64'(0));
    step();

    // Immediate operand: 3 + (-3)
    set_req(0, 32'd3, 32'd100, 32'hFFFF_FFFD, 1'b1, OP_ADD);
    req_valid = 4'b0001;
    @(negedge clk);
    check("t2_ready", 64'(req_ready), 64'(4'b0001));
    step();
    req_valid = '0;
    @(negedge clk);
    check("t2_alu_src", 64'(alu_src), 64'(1));
    check("t2_alu_in1", 64'(alu_in1), 64'(32'hFFFF_FFFD));
    @(negedge clk);
    check("t2_rsp_data", 64'(rsp_data), 64'(0));
    check("t2_rsp_zero", 64'(rsp_zero), 64'(1));
    step();

    // Contention between requesters 0 and 1 from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    glog.delete();
    gcyc.delete();
    set_req(0, 32'd10, 32'd4, 32'd0, 1'b0, OP_SUB);
    set_req(1, 32'd6, 32'd0, 32'd9, 1'b1, OP_AND);
    req_valid = 4'b0011;
    n = 0;
    while (glog.size() < 4 && n < 60) begin
      step();
      n++;
    end
    req_valid = '0;
    check("t3_grant_bound", 64'(n < 60), 64'(1));
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    if (glog.size() >= 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("t3_grant%0d", i), 64'(glog[i]), 64'(exp_g[i]));
      check("t3_throughput", 64'(gcyc[1] - gcyc[0]), 64'(3));
    end
    repeat (3) step();

    // Backpressure; requester 3 withdraws before it could be granted
    mark = glog.size();
    rsp_ready = 1'b0;
    set_req(2, 32'h1234, 32'h0F0F, 32'd0, 1'b0, OP_XOR);
    set_req(1, 32'd20, 32'd22, 32'd0, 1'b0, OP_SUB);
    set_req(3, 32'd1, 32'd1, 32'd0, 1'b0, OP_ADD);
    req_valid = 4'b0100;
    @(negedge clk);
    check("t4_ready", 64'(req_ready), 64'(4'b0100));
    step();
    req_valid = '0;
    step();
    for (int k = 0; k < 4; k++) begin
      if (k == 0) req_valid = 4'b1010;
      if (k == 2) req_valid = 4'b0010;
      @(negedge clk);
      check($sformatf("t4_hold_valid%0d", k), 64'(rsp_valid), 64'(1));
      check($sformatf("t4_hold_data%0d", k), 64'(rsp_data), 64'(32'h1D3B));
      check($sformatf("t4_hold_ready%0d", k), 64'(req_ready), 64'(0));
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t4_handshake_valid", 64'(rsp_valid), 64'(1));
    step();
    @(negedge clk);
    check("t4_idle_valid", 64'(rsp_valid), 64'(0));
    check("t4_waiting_grant", 64'(req_ready), 64'(4'b0010));
    step();
    req_valid = '0;
    repeat (3) step();
    saw3 = 1'b0;
    for (int i = mark; i < glog.size(); i++) if (glog[i] == 3) saw3 = 1'b1;
    check("t4_withdrawn_no_grant", 64'(saw3), 64'(0));

    // Reset in EXEC discards the operation and clears the pointer
    set_req(0, 32'd1, 32'd2, 32'd0, 1'b0, OP_ADD);
    req_valid = 4'b0001;
    @(negedge clk);
    check("t5_ready", 64'(req_ready), 64'(4'b0001));
    step();
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    check("t5_exec_alu_a", 64'(alu_a), 64'(1));
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t5_alu_cleared", 64'(alu_a | alu_in0 | alu_in1), 64'(0));
    check("t5_ctl_cleared", 64'({alu_src, alu_ctrl}), 64'(0));
    check("t5_rsp_cleared", 64'({rsp_valid, rsp_id, rsp_data, rsp_zero}), 64'(0));
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      check($sformatf("t5_no_rsp%0d", k), 64'(rsp_valid), 64'(0));
    end
    step();
    set_req(1, 32'd2, 32'd2, 32'd0, 1'b0, OP_SUB);
    req_valid = 4'b0011;
    @(negedge clk);
    check("t5_ptr_zero", 64'(req_ready), 64'(4'b0001));
    step();
    req_valid = '0;
    repeat (3) step();

    // Wrap-around: grant 3, then 0, then pointer sits at 1
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(3, 32'd8, 32'd8, 32'd0, 1'b0, OP_SUB);
    req_valid = 4'b1000;
    @(negedge clk);
    check("t6_grant3", 64'(req_ready), 64'(4'b1000));
    step();
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    check("t6_rsp3_id", 64'(rsp_id), 64'(3));
    check("t6_rsp3_zero", 64'(rsp_zero), 64'(1));
    step();
    req_valid = 4'b0001;
    @(negedge clk);
    check("t6_grant0", 64'(req_ready), 64'(4'b0001));
    step();
    req_valid = '0;
    step();
    step();
    req_valid = 4'b0011;
    @(negedge clk);
`ifdef ALU_ARB_FIXED_PRIO_EN
    check("t6_ptr_after_wrap", 64'(req_ready), 64'(4'b0001));
`else
    check("t6_ptr_after_wrap", 64'(req_ready), 64'(4'b0010));
`endif
    step();
    req_valid = '0;
    repeat (3) step();

    // Random traffic with hold-until-accepted requests and random backpressure
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      acc = req_ready;
      step();
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          set_req(i, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, $urandom,
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
          req_valid[i] = 1'b1;
        end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (6) step();
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
